// File: rtl/decode_execute_pipe_reg_if.sv
// Decode->Execute bundle interface: the decode-side bundle and pipeline
// control going into the register, the execute-side bundle and
// performance counters coming out of it.
interface decode_execute_pipe_reg_if #(
  parameter int WORD_W = 64,
  parameter int NIB_W  = 4,
  parameter int CNT_W  = 32
);
  // pipeline control
  logic              stall;
  logic              bubble;
  logic              cnt_clear;

  // decode-stage bundle
  logic              d_valid;
  logic [NIB_W-1:0]  d_icode;
  logic [NIB_W-1:0]  d_ifun;
  logic [NIB_W-1:0]  d_regA;
  logic [NIB_W-1:0]  d_regB;
  logic [NIB_W-1:0]  d_stat;
  logic [WORD_W-1:0] d_valC;
  logic [WORD_W-1:0] d_valP;
  logic [WORD_W-1:0] d_valA;
  logic [WORD_W-1:0] d_valB;

  // execute-stage bundle
  logic              e_valid;
  logic [NIB_W-1:0]  e_icode;
  logic [NIB_W-1:0]  e_ifun;
  logic [NIB_W-1:0]  e_regA;
  logic [NIB_W-1:0]  e_regB;
  logic [NIB_W-1:0]  e_stat;
  logic [WORD_W-1:0] e_valC;
  logic [WORD_W-1:0] e_valP;
  logic [WORD_W-1:0] e_valA;
  logic [WORD_W-1:0] e_valB;

  // performance counters
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  // Driver side: pipeline control unit plus decode stage.
  modport master (
    output stall, bubble, cnt_clear,
    output d_valid, d_icode, d_ifun, d_regA, d_regB, d_stat,
    output d_valC, d_valP, d_valA, d_valB,
    input  e_valid, e_icode, e_ifun, e_regA, e_regB, e_stat,
    input  e_valC, e_valP, e_valA, e_valB,
    input  stall_cnt, bubble_cnt
  );

  // The pipeline register itself.
  modport slave (
    input  stall, bubble, cnt_clear,
    input  d_valid, d_icode, d_ifun, d_regA, d_regB, d_stat,
    input  d_valC, d_valP, d_valA, d_valB,
    output e_valid, e_icode, e_ifun, e_regA, e_regB, e_stat,
    output e_valC, e_valP, e_valA, e_valB,
    output stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/decode_execute_pipe_reg.sv
// Y86 Decode->Execute pipeline register with stall/bubble control and
// saturating stall/bubble event counters. Every output is a flop.
// Edge priority: reset > bubble > stall > load. cnt_clear only touches
// the counters and beats any same-cycle count event.
module decode_execute_pipe_reg #(
  parameter int               WORD_W      = 64,
  parameter int               NIB_W       = 4,
  parameter int               CNT_W       = 32,
  parameter logic [NIB_W-1:0] NOP_ICODE   = 4'h1,
  parameter logic [NIB_W-1:0] RNONE       = 4'hF,
  parameter logic [NIB_W-1:0] BUBBLE_STAT = 4'h1
) (
  input  logic                      clock,
  input  logic                      reset,
  decode_execute_pipe_reg_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [NIB_W-1:0]  icode;
    logic [NIB_W-1:0]  ifun;
    logic [NIB_W-1:0]  regA;
    logic [NIB_W-1:0]  regB;
    logic [NIB_W-1:0]  stat;
    logic [WORD_W-1:0] valC;
    logic [WORD_W-1:0] valP;
    logic [WORD_W-1:0] valA;
    logic [WORD_W-1:0] valB;
  } bundle_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bundle injected on reset and on bubble: a non-valid NOP.
  function automatic bundle_t nop_bundle();
    bundle_t b;
    b.valid = 1'b0;
    b.icode = NOP_ICODE;
    b.ifun  = {NIB_W{1'b0}};
    b.regA  = RNONE;
    b.regB  = RNONE;
    b.stat  = BUBBLE_STAT;
    b.valC  = {WORD_W{1'b0}};
    b.valP  = {WORD_W{1'b0}};
    b.valA  = {WORD_W{1'b0}};
    b.valB  = {WORD_W{1'b0}};
    return b;
  endfunction

  // Saturating increment: stays at the maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  bundle_t          bundle_q;
  bundle_t          bundle_d;
  bundle_t          d_bundle_s;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic             stall_evt_s;
  logic             bubble_evt_s;

  // Gather the decode-side fields into one bundle.
  always_comb begin
    d_bundle_s.valid = bus.d_valid;
    d_bundle_s.icode = bus.d_icode;
    d_bundle_s.ifun  = bus.d_ifun;
    d_bundle_s.regA  = bus.d_regA;
    d_bundle_s.regB  = bus.d_regB;
    d_bundle_s.stat  = bus.d_stat;
    d_bundle_s.valC  = bus.d_valC;
    d_bundle_s.valP  = bus.d_valP;
    d_bundle_s.valA  = bus.d_valA;
    d_bundle_s.valB  = bus.d_valB;
  end

  // Next bundle: bubble beats stall, stall beats load.
  always_comb begin
    bundle_d = bundle_q;
    if (bus.bubble) begin
      bundle_d = nop_bundle();
    end else if (bus.stall) begin
      bundle_d = bundle_q;
    end else begin
      bundle_d = d_bundle_s;
    end
  end

  // A stall only counts when it actually holds, i.e. no bubble that cycle.
  always_comb begin
    bubble_evt_s = bus.bubble;
    stall_evt_s  = bus.stall & ~bus.bubble;
  end

  // Next counter values: clear wins over any same-cycle event.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.cnt_clear) begin
      stall_cnt_d  = CNT_ZERO;
      bubble_cnt_d = CNT_ZERO;
    end else begin
      if (stall_evt_s) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (bubble_evt_s) begin
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end
  end

  // State update; synchronous reset overrides everything on its edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      bundle_q     <= nop_bundle();
      stall_cnt_q  <= CNT_ZERO;
      bubble_cnt_q <= CNT_ZERO;
    end else begin
      bundle_q     <= bundle_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Outputs straight from the flops.
  always_comb begin
    bus.e_valid    = bundle_q.valid;
    bus.e_icode    = bundle_q.icode;
    bus.e_ifun     = bundle_q.ifun;
    bus.e_regA     = bundle_q.regA;
    bus.e_regB     = bundle_q.regB;
    bus.e_stat     = bundle_q.stat;
    bus.e_valC     = bundle_q.valC;
    bus.e_valP     = bundle_q.valP;
    bus.e_valA     = bundle_q.valA;
    bus.e_valB     = bundle_q.valB;
    bus.stall_cnt  = stall_cnt_q;
    bus.bubble_cnt = bubble_cnt_q;
  end

endmodule

// File: tb/tb_decode_execute_pipe_reg.sv
// Directed bench for decode_execute_pipe_reg: a default-width instance for
// the pipeline behaviour and a CNT_W=4 instance for counter saturation.
module tb_decode_execute_pipe_reg;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  decode_execute_pipe_reg_if #(.WORD_W(64), .NIB_W(4), .CNT_W(32)) bus ();
  decode_execute_pipe_reg_if #(.WORD_W(64), .NIB_W(4), .CNT_W(4))  bus4 ();

  decode_execute_pipe_reg #(.WORD_W(64), .NIB_W(4), .CNT_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  decode_execute_pipe_reg #(.WORD_W(64), .NIB_W(4), .CNT_W(4)) dut4 (
    .clock(clock),
    .reset(reset),
    .bus  (bus4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, ".valid"}, {63'd0, bus.e_valid}, 64'd0);
    chk({tag, ".icode"}, {60'd0, bus.e_icode}, 64'h1);
    chk({tag, ".ifun"},  {60'd0, bus.e_ifun},  64'h0);
    chk({tag, ".regA"},  {60'd0, bus.e_regA},  64'hF);
    chk({tag, ".regB"},  {60'd0, bus.e_regB},  64'hF);
    chk({tag, ".stat"},  {60'd0, bus.e_stat},  64'h1);
    chk({tag, ".valC"},  bus.e_valC, 64'd0);
    chk({tag, ".valP"},  bus.e_valP, 64'd0);
    chk({tag, ".valA"},  bus.e_valA, 64'd0);
    chk({tag, ".valB"},  bus.e_valB, 64'd0);
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] st,
                       input logic [63:0] c, input logic [63:0] p,
                       input logic [63:0] a, input logic [63:0] b);
    bus.d_valid = v;  bus.d_icode = ic; bus.d_ifun = fn;
    bus.d_regA  = ra; bus.d_regB  = rb; bus.d_stat = st;
    bus.d_valC  = c;  bus.d_valP  = p;  bus.d_valA = a; bus.d_valB = b;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.bubble = 1'b0; bus.cnt_clear = 1'b0;
    bus4.stall = 1'b0; bus4.bubble = 1'b0; bus4.cnt_clear = 1'b0;
    bus4.d_valid = 1'b1; bus4.d_icode = 4'h2; bus4.d_ifun = 4'h0;
    bus4.d_regA = 4'h1; bus4.d_regB = 4'h2; bus4.d_stat = 4'h1;
    bus4.d_valC = 64'h42; bus4.d_valP = 64'h0; bus4.d_valA = 64'h0; bus4.d_valB = 64'h0;
    drive(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 4'h3, 64'h1234, 64'h10, 64'h5, 64'h7);

    // Reset edge: NOP bundle, counters zero.
    step();
    chk_nop("rst");
    chk("rst.stall_cnt",  {32'd0, bus.stall_cnt},  64'd0);
    chk("rst.bubble_cnt", {32'd0, bus.bubble_cnt}, 64'd0);

    // First load after reset.
    reset = 1'b0;
    step();
    chk("ld.valid", {63'd0, bus.e_valid}, 64'd1);
    chk("ld.icode", {60'd0, bus.e_icode}, 64'h6);
    chk("ld.ifun",  {60'd0, bus.e_ifun},  64'h0);
    chk("ld.regA",  {60'd0, bus.e_regA},  64'h2);
    chk("ld.regB",  {60'd0, bus.e_regB},  64'h3);
    chk("ld.stat",  {60'd0, bus.e_stat},  64'h3);
    chk("ld.valC",  bus.e_valC, 64'h1234);
    chk("ld.valP",  bus.e_valP, 64'h10);
    chk("ld.valA",  bus.e_valA, 64'h5);
    chk("ld.valB",  bus.e_valB, 64'h7);

    // Stall for 3 cycles while decode moves on: outputs hold.
    bus.stall = 1'b1;
    drive(1'b1, 4'h3, 4'h0, 4'hF, 4'h4, 4'h1, 64'hDEAD, 64'h20, 64'h9, 64'hA);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.valC",  bus.e_valC, 64'h1234);
      chk("stall.icode", {60'd0, bus.e_icode}, 64'h6);
      chk("stall.cnt",   {32'd0, bus.stall_cnt}, 64'(i + 1));
    end

    // First unstalled edge loads the current decode values.
    bus.stall = 1'b0;
    step();
    chk("unstall.valC",  bus.e_valC, 64'hDEAD);
    chk("unstall.icode", {60'd0, bus.e_icode}, 64'h3);
    chk("unstall.valA",  bus.e_valA, 64'h9);
    chk("unstall.cnt",   {32'd0, bus.stall_cnt}, 64'd3);

    // Clear counters; bundle still loads normally.
    bus.cnt_clear = 1'b1;
    drive(1'b1, 4'h2, 4'h0, 4'h1, 4'h5, 4'h1, 64'h0, 64'h22, 64'h33, 64'h44);
    step();
    bus.cnt_clear = 1'b0;
    chk("clr.stall_cnt", {32'd0, bus.stall_cnt}, 64'd0);
    chk("clr.icode",     {60'd0, bus.e_icode},   64'h2);
    chk("clr.valB",      bus.e_valB, 64'h44);

    // Stall and bubble together: bubble wins, only bubble_cnt moves.
    bus.stall  = 1'b1;
    bus.bubble = 1'b1;
    step();
    chk_nop("sb");
    chk("sb.bubble_cnt", {32'd0, bus.bubble_cnt}, 64'd1);
    chk("sb.stall_cnt",  {32'd0, bus.stall_cnt},  64'd0);

    // Two more bubble cycles: two more NOPs.
    bus.stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_nop("bub");
      chk("bub.cnt", {32'd0, bus.bubble_cnt}, 64'(i + 2));
    end

    // Load, then stall 5 cycles to bring stall_cnt to 5.
    bus.bubble = 1'b0;
    drive(1'b1, 4'h7, 4'h3, 4'hF, 4'hF, 4'h1, 64'hBEEF, 64'h99, 64'h0, 64'h0);
    step();
    chk("ld2.valC", bus.e_valC, 64'hBEEF);
    bus.stall = 1'b1;
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h1, 64'h1, 64'h1, 64'h1);
    repeat (5) step();
    chk("stall5.cnt", {32'd0, bus.stall_cnt}, 64'd5);

    // Stall plus clear on the same edge: clear wins, bundle held.
    bus.cnt_clear = 1'b1;
    step();
    bus.cnt_clear = 1'b0;
    chk("sclr.stall_cnt",  {32'd0, bus.stall_cnt},  64'd0);
    chk("sclr.bubble_cnt", {32'd0, bus.bubble_cnt}, 64'd0);
    chk("sclr.valC",       bus.e_valC, 64'hBEEF);
    chk("sclr.ifun",       {60'd0, bus.e_ifun}, 64'h3);

    // One more stall so counters are non-zero, then reset mid-stall.
    step();
    chk("pre_rst.stall_cnt", {32'd0, bus.stall_cnt}, 64'd1);
    reset = 1'b1;
    step();
    chk_nop("rst2");
    chk("rst2.stall_cnt",  {32'd0, bus.stall_cnt},  64'd0);
    chk("rst2.bubble_cnt", {32'd0, bus.bubble_cnt}, 64'd0);

    // Load resumes on the edge after reset drops.
    reset = 1'b0;
    bus.stall = 1'b0;
    drive(1'b1, 4'h8, 4'h0, 4'h4, 4'hF, 4'h1, 64'h500, 64'h509, 64'h0, 64'h0);
    step();
    chk("post_rst.icode", {60'd0, bus.e_icode}, 64'h8);
    chk("post_rst.valid", {63'd0, bus.e_valid}, 64'd1);
    chk("post_rst.valP",  bus.e_valP, 64'h509);

    // Saturation on the 4-bit counter instance: 20 stall cycles.
    bus4.stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat.cnt14", {60'd0, bus4.stall_cnt}, 64'd14);
      if (i == 15) chk("sat.cnt15", {60'd0, bus4.stall_cnt}, 64'd15);
      if (i == 20) chk("sat.cnt20", {60'd0, bus4.stall_cnt}, 64'd15);
    end
    chk("sat.valC", bus4.e_valC, 64'h42);
    bus4.stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_execute_pipe_reg.md
# decode_execute_pipe_reg

Parametrised Decode→Execute pipeline register for the Y86 pipeline with stall and bubble control. It captures the decode-stage bundle (icode, ifun, register IDs, valC, valP, valA, valB, stat, valid) on each rising clock edge. A stall holds the current contents; a bubble injects a NOP. It also keeps saturating stall and bubble event counters for performance debug. It sits between the decode stage and the ALU/condition-code logic, driven by the pipeline control unit.

## Interface
- WORD_W, 64, width of valC/valP/valA/valB
- NIB_W, 4, width of icode/ifun/regA/regB/stat
- CNT_W, 32, width of each event counter
- NOP_ICODE, 4'h1, icode injected on bubble/reset
- RNONE, 4'hF, register ID injected on bubble/reset
- BUBBLE_STAT, 4'h1, stat injected on bubble/reset

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold current contents
- bubble  in  1  inject NOP on next edge
- cnt_clear  in  1  synchronous clear of both counters
- d_valid  in  1  decode bundle carries a real instruction
- d_icode, d_ifun, d_regA, d_regB, d_stat  in  NIB_W each  decode fields
- d_valC, d_valP, d_valA, d_valB  in  WORD_W each  decode values
- e_valid  out  1  registered valid
- e_icode, e_ifun, e_regA, e_regB, e_stat  out  NIB_W each  registered fields
- e_valC, e_valP, e_valA, e_valB  out  WORD_W each  registered values
- stall_cnt  out  CNT_W  cycles with stall taking effect
- bubble_cnt  out  CNT_W  cycles with bubble taking effect

## Operation
- Per-edge priority: reset > bubble > stall > load.
- reset: e_icode=NOP_ICODE, e_ifun=0, e_regA=e_regB=RNONE, e_valC/valP/valA/valB=0, e_stat=BUBBLE_STAT, e_valid=0, stall_cnt=bubble_cnt=0.
- bubble (reset low): bundle outputs take the same values as reset; e_valid=0; bubble_cnt increments; counters are not cleared.
- stall (reset, bubble low): all e_* outputs hold; stall_cnt increments.
- load (none asserted): every e_* output takes its d_* input; e_valid=d_valid.
- stall and bubble together: bubble wins. Bubble is applied, only bubble_cnt increments, and stall_cnt is unchanged.
- Counters:
  - Saturate at 2^CNT_W−1; never wrap.
  - cnt_clear zeroes both counters. If a count event occurs in the same cycle, cnt_clear wins and the result is 0.
  - cnt_clear does not affect the pipeline bundle.
- No combinational path from any input to any output. All outputs come directly from flops.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N, stable for cycle N+1.
- A stall held for k consecutive cycles holds outputs for k cycles. The next unstalled edge loads the then-current d_* values.
- A bubble asserted for k consecutive cycles produces k NOP cycles on the outputs.
- Reset mid-stream overrides everything on that edge. The first load after reset deasserts occurs on the following edge.
- Outputs after power-up are undefined until the first reset edge.

## Test plan
- Reset then load: assert reset 1 cycle, then d_icode=6, d_ifun=0, d_regA=2, d_regB=3, d_valA=5, d_valB=7, d_valid=1. Outputs show icode=1, regA=regB=F, valid=0 after the reset edge, then 6/0/2/3/5/7, valid=1 one edge later.
- Stall hold: load valC=0x1234, then assert stall 3 cycles while d_valC changes to 0xDEAD. e_valC stays 0x1234 for 3 cycles, becomes 0xDEAD on the first unstalled edge, and stall_cnt=3.
- Bubble vs stall: assert stall=1 and bubble=1 together for 1 cycle. Outputs are a NOP (icode=1, valid=0), bubble_cnt=1, stall_cnt=0.
- Counter saturation (CNT_W=4): hold stall 20 cycles. stall_cnt reaches 15 and stays at 15.
- Clear precedence: stall=1 and cnt_clear=1 on the same edge with stall_cnt=5. stall_cnt=0 and bundle outputs held.
- Reset mid-stall: stall=1 and reset=1 on the same edge. Outputs take reset values and both counters are 0.
